// File: rtl/uart_loader_if.sv
// Loader-side UART byte stream and RAM port bundle for uart_loader.
// master = loader, slave = UART/RAM/cpu environment.
interface uart_loader_if #(
  parameter int addr_width = 9
);
  logic                  received;
  logic [7:0]            rx_byte;
  logic                  is_transmitting;
  logic [7:0]            tx_byte;
  logic                  transmit;
  logic                  ram_sel;
  logic [addr_width-1:0] l_waddr;
  logic [7:0]            dwrite;
  logic                  write_en;
  logic [addr_width-1:0] l_raddr;
  logic [7:0]            dread;
  logic [addr_width-1:0] startaddr;
  logic                  cpu_start;
  logic                  cpu_halted;

  modport master (
    input  received, rx_byte, is_transmitting, dread, cpu_halted,
    output tx_byte, transmit, ram_sel, l_waddr, dwrite, write_en,
           l_raddr, startaddr, cpu_start
  );

  modport slave (
    output received, rx_byte, is_transmitting, dread, cpu_halted,
    input  tx_byte, transmit, ram_sel, l_waddr, dwrite, write_en,
           l_raddr, startaddr, cpu_start
  );
endinterface

// File: rtl/uart_loader.sv
// Serial monitor/loader: 'L' load, 'D' dump, 'G' go commands over the UART byte stream.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 data checksum on 'L'.
module uart_loader #(
  parameter int         addr_width = 9,
  parameter logic [7:0] ACK_BYTE   = 8'h2B,
  parameter logic [7:0] NAK_BYTE   = 8'h3F
) (
  input logic           clk,
  input logic           rst,
  uart_loader_if.master bus
);
  typedef enum logic [3:0] {
    IDLE    = 4'd0,  ADDRH   = 4'd1,  ADDRL = 4'd2,  LEN = 4'd3,
    DATA    = 4'd4,  CHK     = 4'd5,  DRD   = 4'd6,  DW1 = 4'd7,
    DW2     = 4'd8,  DTX     = 4'd9,  GO    = 4'd10, RUN = 4'd11,
    SENDACK = 4'd12, SENDNAK = 4'd13
  } state_t;

  localparam logic [7:0]            CMD_L    = 8'h4C;
  localparam logic [7:0]            CMD_D    = 8'h44;
  localparam logic [7:0]            CMD_G    = 8'h47;
  localparam logic [addr_width-1:0] ADDR_ONE = {{(addr_width-1){1'b0}}, 1'b1};

  state_t                state_r, state_nxt;
  logic [7:0]            cmd_r, cmd_nxt;
  logic [7:0]            addr_hi_r, addr_hi_nxt;
  logic [addr_width-1:0] addr_r, addr_nxt;
  logic [8:0]            count_r, count_nxt;
  logic [7:0]            tx_byte_r, tx_byte_nxt;
  logic                  transmit_r, transmit_nxt;
  logic                  ram_sel_r, ram_sel_nxt;
  logic [addr_width-1:0] l_waddr_r, l_waddr_nxt;
  logic [7:0]            dwrite_r, dwrite_nxt;
  logic                  write_en_r, write_en_nxt;
  logic [addr_width-1:0] l_raddr_r, l_raddr_nxt;
  logic [addr_width-1:0] startaddr_r, startaddr_nxt;
  logic                  cpu_start_r, cpu_start_nxt;
  logic                  tx_free_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_r, sum_nxt;
`endif

  // The UART only raises busy a cycle after our strobe, so our own pulse also blocks.
  assign tx_free_s = !bus.is_transmitting && !transmit_r;

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state_r;
    cmd_nxt       = cmd_r;
    addr_hi_nxt   = addr_hi_r;
    addr_nxt      = addr_r;
    count_nxt     = count_r;
    tx_byte_nxt   = tx_byte_r;
    transmit_nxt  = 1'b0;
    ram_sel_nxt   = ram_sel_r;
    l_waddr_nxt   = l_waddr_r;
    dwrite_nxt    = dwrite_r;
    write_en_nxt  = 1'b0;
    l_raddr_nxt   = l_raddr_r;
    startaddr_nxt = startaddr_r;
    cpu_start_nxt = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_nxt       = sum_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.received) begin
          cmd_nxt = bus.rx_byte;
          if (bus.rx_byte == CMD_L || bus.rx_byte == CMD_D || bus.rx_byte == CMD_G) begin
            state_nxt = ADDRH;
          end else begin
            state_nxt = SENDNAK;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ADDRH: begin
        if (bus.received) begin
          addr_hi_nxt = bus.rx_byte;
          state_nxt   = ADDRL;
        end else begin
          state_nxt = ADDRH;
        end
      end
      ADDRL: begin
        if (bus.received) begin
          addr_nxt  = addr_width'({addr_hi_r, bus.rx_byte});
          state_nxt = (cmd_r == CMD_G) ? GO : LEN;
        end else begin
          state_nxt = ADDRL;
        end
      end
      LEN: begin
        if (bus.received) begin
          count_nxt = (bus.rx_byte == 8'h00) ? 9'd256 : {1'b0, bus.rx_byte};
          state_nxt = (cmd_r == CMD_L) ? DATA : DRD;
`ifdef LOADER_CHECKSUM_EN
          sum_nxt   = 8'h00;
`endif
        end else begin
          state_nxt = LEN;
        end
      end
      DATA: begin
        if (bus.received) begin
          l_waddr_nxt  = addr_r;
          dwrite_nxt   = bus.rx_byte;
          write_en_nxt = 1'b1;
          addr_nxt     = addr_r + ADDR_ONE;
          count_nxt    = count_r - 9'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_nxt      = sum_r + bus.rx_byte;
          state_nxt    = (count_r == 9'd1) ? CHK : DATA;
`else
          state_nxt    = (count_r == 9'd1) ? SENDACK : DATA;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (bus.received) begin
          state_nxt = (bus.rx_byte == sum_r) ? SENDACK : SENDNAK;
        end else begin
          state_nxt = CHK;
        end
      end
`endif
      DRD: begin
        l_raddr_nxt = addr_r;
        state_nxt   = DW1;
      end
      DW1: state_nxt = DW2;
      DW2: state_nxt = DTX;
      DTX: begin
        if (tx_free_s) begin
          tx_byte_nxt  = bus.dread;
          transmit_nxt = 1'b1;
          addr_nxt     = addr_r + ADDR_ONE;
          count_nxt    = count_r - 9'd1;
          state_nxt    = (count_r == 9'd1) ? SENDACK : DRD;
        end else begin
          state_nxt = DTX;
        end
      end
      GO: begin
        startaddr_nxt = addr_r;
        ram_sel_nxt   = 1'b0;
        cpu_start_nxt = 1'b1;
        state_nxt     = RUN;
      end
      RUN: begin
        if (bus.cpu_halted) begin
          ram_sel_nxt = 1'b1;
          state_nxt   = SENDACK;
        end else begin
          state_nxt = RUN;
        end
      end
      SENDACK, SENDNAK: begin
        if (tx_free_s) begin
          tx_byte_nxt  = (state_r == SENDACK) ? ACK_BYTE : NAK_BYTE;
          transmit_nxt = 1'b1;
          state_nxt    = IDLE;
        end else begin
          state_nxt = state_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cmd_r       <= 8'h00;
      addr_hi_r   <= 8'h00;
      addr_r      <= {addr_width{1'b0}};
      count_r     <= 9'd0;
      tx_byte_r   <= 8'h00;
      transmit_r  <= 1'b0;
      ram_sel_r   <= 1'b1;
      l_waddr_r   <= {addr_width{1'b0}};
      dwrite_r    <= 8'h00;
      write_en_r  <= 1'b0;
      l_raddr_r   <= {addr_width{1'b0}};
      startaddr_r <= {addr_width{1'b0}};
      cpu_start_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_r       <= 8'h00;
`endif
    end else begin
      state_r     <= state_nxt;
      cmd_r       <= cmd_nxt;
      addr_hi_r   <= addr_hi_nxt;
      addr_r      <= addr_nxt;
      count_r     <= count_nxt;
      tx_byte_r   <= tx_byte_nxt;
      transmit_r  <= transmit_nxt;
      ram_sel_r   <= ram_sel_nxt;
      l_waddr_r   <= l_waddr_nxt;
      dwrite_r    <= dwrite_nxt;
      write_en_r  <= write_en_nxt;
      l_raddr_r   <= l_raddr_nxt;
      startaddr_r <= startaddr_nxt;
      cpu_start_r <= cpu_start_nxt;
`ifdef LOADER_CHECKSUM_EN
      sum_r       <= sum_nxt;
`endif
    end
  end

  assign bus.tx_byte   = tx_byte_r;
  assign bus.transmit  = transmit_r;
  assign bus.ram_sel   = ram_sel_r;
  assign bus.l_waddr   = l_waddr_r;
  assign bus.dwrite    = dwrite_r;
  assign bus.write_en  = write_en_r;
  assign bus.l_raddr   = l_raddr_r;
  assign bus.startaddr = startaddr_r;
  assign bus.cpu_start = cpu_start_r;
endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: random L/D/G traffic against an array-based command model.
// Honours LOADER_CHECKSUM_EN the same way as the design.
module tb_uart_loader;
  localparam int         AW  = 9;
  localparam int         MSZ = 1 << AW;
  localparam logic [7:0] ACK = 8'h2B;
  localparam logic [7:0] NAK = 8'h3F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_loader_if #(.addr_width(AW)) bus ();
  uart_loader #(.addr_width(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0]  ram     [0:MSZ-1];
  logic [7:0]  ref_mem [0:MSZ-1];
  logic [7:0]  rd_pipe;
  int          busy_cnt = 0;
  logic [16:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [8:0]  exp_st[$];
  int          checks = 0;
  int          passes = 0;

  // RAM with two-cycle registered read, plus a UART tx that stays busy a few cycles.
  always @(posedge clk) begin
    if (bus.write_en) ram[bus.l_waddr] <= bus.dwrite;
    rd_pipe  <= ram[bus.l_raddr];
    bus.dread <= rd_pipe;
    if (bus.transmit) busy_cnt <= $urandom_range(3, 10);
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.is_transmitting = (busy_cnt != 0);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input int act);
    checks++;
    $display("FAIL %s: got %0h, expected no event", name, act);
  endtask

  // Monitor: every output event is matched against the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.write_en) begin
        chk("wr_ram_sel", int'(bus.ram_sel), 1);
        if (exp_wr.size() == 0) unexpected("wr_extra", int'({bus.l_waddr, bus.dwrite}));
        else begin
          logic [16:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", int'(bus.l_waddr), int'(e[16:8]));
          chk("wr_data", int'(bus.dwrite), int'(e[7:0]));
        end
      end
      if (bus.transmit) begin
        if (exp_tx.size() == 0) unexpected("tx_extra", int'(bus.tx_byte));
        else chk("tx_byte", int'(bus.tx_byte), int'(exp_tx.pop_front()));
      end
      if (bus.cpu_start) begin
        chk("start_ram_sel", int'(bus.ram_sel), 0);
        if (exp_st.size() == 0) unexpected("start_extra", int'(bus.startaddr));
        else chk("startaddr", int'(bus.startaddr), int'(exp_st.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.received = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.received = 1'b0;
    repeat ($urandom_range(1, 6)) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_wr.size() + exp_tx.size() + exp_st.size()) != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      $display("FAIL timeout: %0d expectations outstanding, expected 0",
               exp_wr.size() + exp_tx.size() + exp_st.size());
      exp_wr.delete();
      exp_tx.delete();
      exp_st.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic int addr_of(input logic [7:0] hi, input logic [7:0] lo);
    return int'({hi, lo}) % MSZ;
  endfunction

  // A nonzero chk_delta corrupts the trailing checksum when that feature is built in.
  task automatic cmd_load(input logic [7:0] hi, input logic [7:0] lo,
                          input logic [7:0] d[$], input logic [7:0] chk_delta);
    int         a = addr_of(hi, lo);
    logic [7:0] s = 8'h00;
    logic [7:0] lb = 8'(d.size());
    foreach (d[i]) begin
      ref_mem[(a + i) % MSZ] = d[i];
      exp_wr.push_back({9'((a + i) % MSZ), d[i]});
      s = s + d[i];
    end
`ifdef LOADER_CHECKSUM_EN
    exp_tx.push_back((chk_delta == 8'h00) ? ACK : NAK);
`else
    exp_tx.push_back(ACK);
`endif
    send_byte(8'h4C); send_byte(hi); send_byte(lo); send_byte(lb);
    foreach (d[i]) send_byte(d[i]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(s + chk_delta);
`endif
    wait_done();
  endtask

  task automatic cmd_dump(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] lb);
    int a = addr_of(hi, lo);
    int n = (lb == 8'h00) ? 256 : int'(lb);
    for (int i = 0; i < n; i++) exp_tx.push_back(ref_mem[(a + i) % MSZ]);
    exp_tx.push_back(ACK);
    send_byte(8'h44); send_byte(hi); send_byte(lo); send_byte(lb);
    wait_done();
  endtask

  task automatic cmd_go(input logic [7:0] hi, input logic [7:0] lo);
    exp_st.push_back(9'(addr_of(hi, lo)));
    send_byte(8'h47); send_byte(hi); send_byte(lo);
    wait_done();
    chk("run_ram_sel", int'(bus.ram_sel), 0);
    send_byte(8'h4C); send_byte(8'h5A); send_byte(8'($urandom));
    exp_tx.push_back(ACK);
    @(negedge clk);
    bus.received   = 1'b1;
    bus.rx_byte    = 8'h44;
    bus.cpu_halted = 1'b1;
    @(negedge clk);
    bus.received   = 1'b0;
    bus.cpu_halted = 1'b0;
    wait_done();
    chk("halt_ram_sel", int'(bus.ram_sel), 1);
  endtask

  task automatic cmd_bad(input logic [7:0] b);
    exp_tx.push_back(NAK);
    send_byte(b);
    wait_done();
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] b;
    for (int i = 0; i < MSZ; i++) begin
      ram[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst            = 1'b0;
    bus.received   = 1'b0;
    bus.rx_byte    = 8'h00;
    bus.cpu_halted = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ram_sel", int'(bus.ram_sel), 1);
    chk("rst_write_en", int'(bus.write_en), 0);
    chk("rst_transmit", int'(bus.transmit), 0);
    chk("rst_cpu_start", int'(bus.cpu_start), 0);
    chk("rst_l_waddr", int'(bus.l_waddr), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    d = '{8'hAA, 8'hBB, 8'hCC};
    cmd_load(8'h00, 8'h10, d, 8'h00);
    d = '{8'h11, 8'h22};
    cmd_load(8'h01, 8'hFF, d, 8'h00);
    cmd_dump(8'h00, 8'h10, 8'h03);
    cmd_dump(8'h01, 8'hFF, 8'h02);
    cmd_go(8'h00, 8'h20);
    cmd_go(8'hFE, 8'h20);
    cmd_bad(8'h5A);
    do b = 8'($urandom); while (b == 8'h4C || b == 8'h44 || b == 8'h47);
    cmd_bad(b);
`ifdef LOADER_CHECKSUM_EN
    d = '{8'h01, 8'h02};
    cmd_load(8'h00, 8'h00, d, 8'h01);
    cmd_load(8'h00, 8'h00, d, 8'h00);
`endif

    for (int it = 0; it < 8; it++) begin
      logic [7:0] hi, lo;
      hi = 8'($urandom);
      lo = 8'($urandom);
      d.delete();
      for (int k = 0; k < int'($urandom_range(1, 24)); k++) d.push_back(8'($urandom));
      cmd_load(hi, lo, d, (it % 3 == 2) ? 8'($urandom_range(1, 255)) : 8'h00);
      cmd_dump(hi, lo + 8'($urandom_range(0, 4)), 8'($urandom_range(1, 8)));
    end

    d.delete();
    for (int k = 0; k < 256; k++) d.push_back(8'($urandom));
    cmd_load(8'h01, 8'h80, d, 8'h00);
    cmd_dump(8'h00, 8'h00, 8'h00);

    // Reset in the middle of a load: written bytes survive, the command does not.
    ref_mem[9'h040] = 8'hA5;
    ref_mem[9'h041] = 8'h5B;
    exp_wr.push_back({9'h040, 8'hA5});
    exp_wr.push_back({9'h041, 8'h5B});
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h40); send_byte(8'h05);
    send_byte(8'hA5); send_byte(8'h5B);
    wait_done();
    rst = 1'b0;
    #1;
    chk("midrst_ram_sel", int'(bus.ram_sel), 1);
    chk("midrst_transmit", int'(bus.transmit), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmd_dump(8'h00, 8'h40, 8'h02);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
